// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues single-outstanding memory reads and buffers
// returned words, tagged with their fetch address, in a small FIFO queue.
module fetch_unit #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 9,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [1:0]                   mem_cmd,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic [DATA_W-1:0]            mdata,
   output logic [DATA_W-1:0]            instr,
   output logic [ADDR_W-1:0]            instr_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   input  logic                         redirect,
   input  logic [ADDR_W-1:0]            redirect_pc,
   input  logic                         halt,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC0     = ADDR_W'(RESET_PC);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] tag;
   logic [0:0]        slot_state;
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];

   logic              inflight;
   logic              deq;
   logic              enq;
   logic              issue;
   logic [CW:0]       occupancy;

   assign inflight  = (slot_state == ST_REQ);
   assign deq       = instr_valid & instr_ready;
   assign enq       = inflight & ~redirect;

   // Credit check: words held plus the one in flight, less the word leaving now.
   assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(deq);
   assign issue     = reset & ~halt & ~redirect & (occupancy < DEPTH_C);

   assign mem_cmd     = issue ? 2'b01 : 2'b00;
   assign mem_addr    = fpc;
   assign instr_valid = (count != '0);
   assign instr       = data_mem[head];
   assign instr_pc    = pc_mem[head];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc        <= PC0;
         tag        <= '0;
         slot_state <= ST_IDLE;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else if (redirect) begin
         // Flush wins over any same-cycle enqueue or dequeue.
         fpc        <= redirect_pc;
         slot_state <= ST_IDLE;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         if (issue) begin
            fpc <= fpc + 1'b1;
            tag <= fpc;
         end
         slot_state <= issue ? ST_REQ : ST_IDLE;
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         count <= count + CW'(enq) - CW'(deq);
      end
   end

   // NOTE: queue storage is deliberately not reset; pointers and count define
   // validity, so the array maps onto plain RAM/register-file cells.
   always_ff @(posedge clk) begin
      if (enq) begin
         data_mem[tail] <= mdata;
         pc_mem[tail]   <= tag;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_fetch_unit;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              reset;
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mdata;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halt;
   logic [2:0]        count;

   fetch_unit #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(0)
   ) dut (
      .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .mdata(mdata), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: word[a] = a + 0x100 one cycle after a read; noise otherwise.
   always @(posedge clk) begin
      if (mem_cmd == 2'b01) mdata <= 16'(mem_addr) + 16'h0100;
      else                  mdata <= 16'($urandom);
   end

   int n_pass;
   int n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: queue of fetch addresses held, one optional pending read.
   logic [ADDR_W-1:0] q_m[$];
   int                pend_m;
   logic [ADDR_W-1:0] pend_pc_m;
   logic [ADDR_W-1:0] fpc_m;

   task automatic model_clear();
      q_m.delete();
      pend_m = 0;
      pend_pc_m = '0;
      fpc_m = '0;
   endtask

   task automatic step(input logic rst_v, input logic rdy_v, input logic halt_v,
                       input logic redir_v, input logic [ADDR_W-1:0] rpc_v);
      int deq_m;
      int issue_m;
      @(negedge clk);
      reset = rst_v; instr_ready = rdy_v; halt = halt_v;
      redirect = redir_v; redirect_pc = rpc_v;
      #1;
      if (!rst_v) model_clear();
      deq_m   = (q_m.size() > 0 && rdy_v) ? 1 : 0;
      issue_m = (rst_v && !halt_v && !redir_v &&
                 (q_m.size() + pend_m - deq_m < DEPTH)) ? 1 : 0;
      check("mem_cmd", 32'(mem_cmd), 32'(issue_m));
      check("mem_addr", 32'(mem_addr), 32'(fpc_m));
      check("count", 32'(count), 32'(q_m.size()));
      check("instr_valid", 32'(instr_valid), (q_m.size() > 0) ? 32'd1 : 32'd0);
      if (q_m.size() > 0) begin
         check("instr_pc", 32'(instr_pc), 32'(q_m[0]));
         check("instr", 32'(instr), 32'(q_m[0]) + 32'h100);
      end
      if (rst_v) begin
         if (redir_v) begin
            q_m.delete();
            pend_m = 0;
            fpc_m  = rpc_v;
         end else begin
            if (deq_m != 0) void'(q_m.pop_front());
            if (pend_m != 0) q_m.push_back(pend_pc_m);
            pend_m    = issue_m;
            pend_pc_m = fpc_m;
            if (issue_m != 0) fpc_m = fpc_m + 9'd1;
         end
      end
   endtask

   task automatic run(input logic rdy_v, input int n);
      for (int i = 0; i < n; i++) step(1'b1, rdy_v, 1'b0, 1'b0, 9'h000);
   endtask

   typedef struct {
      logic              ready;
      logic              halt;
      logic              redir;
      logic [ADDR_W-1:0] rpc;
      logic [1:0]        e_cmd;
      logic [ADDR_W-1:0] e_addr;
      logic              e_valid;
      logic [ADDR_W-1:0] e_pc;
      logic [2:0]        e_count;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int rdy, input int hlt, input int rd, input int rpc,
                          input int cmd, input int addr, input int vld, input int pc,
                          input int cnt);
      vec_t v;
      v.ready = 1'(rdy);  v.halt = 1'(hlt);     v.redir = 1'(rd);
      v.rpc = 9'(rpc);    v.e_cmd = 2'(cmd);    v.e_addr = 9'(addr);
      v.e_valid = 1'(vld); v.e_pc = 9'(pc);     v.e_count = 3'(cnt);
      vecs.push_back(v);
   endtask

   logic [ADDR_W-1:0] held;
   int                found;

   initial begin
      n_pass = 0; n_total = 0;
      reset = 1'b0; instr_ready = 1'b0; halt = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      model_clear();

      // Streaming from reset, then a redirect near the top of the address space.
      //       rdy hlt rd  rpc    cmd addr   vld pc     cnt
      add_vec(1,  0,  0,  0,     1,  'h000, 0,  'h000, 0);
      add_vec(1,  0,  0,  0,     1,  'h001, 0,  'h000, 0);
      add_vec(1,  0,  0,  0,     1,  'h002, 1,  'h000, 1);
      add_vec(1,  0,  0,  0,     1,  'h003, 1,  'h001, 1);
      add_vec(1,  0,  0,  0,     1,  'h004, 1,  'h002, 1);
      add_vec(1,  0,  1,  'h1FE, 0,  'h005, 1,  'h003, 1);
      add_vec(1,  0,  0,  0,     1,  'h1FE, 0,  'h000, 0);
      add_vec(1,  0,  0,  0,     1,  'h1FF, 0,  'h000, 0);
      add_vec(1,  0,  0,  0,     1,  'h000, 1,  'h1FE, 1);
      add_vec(1,  0,  0,  0,     1,  'h001, 1,  'h1FF, 1);
      add_vec(1,  0,  0,  0,     1,  'h002, 1,  'h000, 1);
      add_vec(1,  0,  0,  0,     1,  'h003, 1,  'h001, 1);

      // Reset state.
      step(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
      check("rst_mem_cmd", 32'(mem_cmd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'h000);
      check("rst_valid", 32'(instr_valid), 32'd0);

      foreach (vecs[i]) begin
         step(1'b1, vecs[i].ready, vecs[i].halt, vecs[i].redir, vecs[i].rpc);
         check($sformatf("vec%0d_cmd", i), 32'(mem_cmd), 32'(vecs[i].e_cmd));
         check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
         check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
         if (vecs[i].e_valid) begin
            check($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(vecs[i].e_pc));
            check($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].e_pc) + 32'h100);
         end
      end

      // Consumer stalls: queue saturates, issue stops, then drains in order.
      run(1'b0, 10);
      check("stall_count_full", 32'(count), 32'd4);
      check("stall_no_issue", 32'(mem_cmd), 32'd0);
      run(1'b1, 8);

      // Redirect with count=3 and a read in flight, plus a simultaneous dequeue.
      step(1'b1, 1'b1, 1'b0, 1'b1, 9'h100);
      run(1'b0, 4);
      step(1'b1, 1'b1, 1'b0, 1'b1, 9'h040);
      check("redir_pre_count", 32'(count), 32'd3);
      step(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
      check("redir_count_zero", 32'(count), 32'd0);
      check("redir_valid_zero", 32'(instr_valid), 32'd0);
      found = 0;
      for (int i = 0; i < 6 && found == 0; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
         if (instr_valid) found = 1;
      end
      check("redir_first_seen", 32'(found), 32'd1);
      if (found != 0) check("redir_first_pc", 32'(instr_pc), 32'h040);

      // Halt for 5 cycles while draining: fetch PC holds, queue empties.
      run(1'b1, 3);
      held = fpc_m;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 9'h000);
         check("halt_addr_held", 32'(mem_addr), 32'(held));
      end
      check("halt_drained", 32'(instr_valid), 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
      check("halt_resume_cmd", 32'(mem_cmd), 32'd1);
      check("halt_resume_addr", 32'(mem_addr), 32'(held));
      run(1'b1, 4);

      // Asynchronous reset mid-stream with count=2 and a read in flight.
      step(1'b1, 1'b1, 1'b0, 1'b1, 9'h0A0);
      run(1'b0, 4);
      check("rst_pre_count", 32'(count), 32'd2);
      reset = 1'b0;
      #1;
      model_clear();
      check("arst_count", 32'(count), 32'd0);
      check("arst_valid", 32'(instr_valid), 32'd0);
      check("arst_cmd", 32'(mem_cmd), 32'd0);
      check("arst_addr", 32'(mem_addr), 32'h000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
      step(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
      check("arst_restart_cmd", 32'(mem_cmd), 32'd1);
      check("arst_restart_addr", 32'(mem_addr), 32'h000);
      run(1'b1, 4);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic              r_rdy, r_hlt, r_rd;
         logic [ADDR_W-1:0] r_pc;
         r_rdy = ($urandom_range(0, 3) != 0);
         r_hlt = ($urandom_range(0, 9) == 0);
         r_rd  = ($urandom_range(0, 19) == 0);
         r_pc  = ($urandom_range(0, 3) == 0) ? 9'h1FC + 9'($urandom_range(0, 3))
                                              : 9'($urandom);
         step(1'b1, r_rdy, r_hlt, r_rd, r_pc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
